dpmem_rd_stream: RTL and testbench

- Read-side engine for the write-first dual-port RAM. It takes a (base address, length) command and issues sequential reads on one RAM port.
- It absorbs the RAM read latency (1 or 2 cycles, depending on the RAM output register) and presents the words as a valid/ready stream with a last flag.
- It sits next to a RAM port whose other port is filled by a writer. It turns stored buffers into streams for downstream consumers, with full backpressure support.

---
 rtl/dpmem_rd_stream.sv | 135 +++++++++++++
 tb/tb_dpmem_rd_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpmem_rd_stream.sv
// Read-side streaming engine for one port of a dual-port RAM: turns (addr, len)
// commands into sequential reads and a valid/ready word stream with a last flag.
module dpmem_rd_stream #(
    parameter int DEPTH      = 10,
    parameter int WIDTH      = 32,
    parameter int OUTREG     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DEPTH-1:0] cmd_addr,
    input  logic [DEPTH:0]   cmd_len,
    output logic             mem_en,
    output logic [DEPTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_do,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);
    localparam int L  = 1 + OUTREG;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [DEPTH:0] LEN_ONE = 1;
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]  PTR_MAX = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t           state, state_next;
    logic [DEPTH-1:0] addr;
    logic [DEPTH:0]   rem;
    logic [CW-1:0]    credit, credit_next;
    logic             issue, last_issue, push, pop;
    logic             mem_last;
    logic [L-1:0]     pipe_en, pipe_last;
    logic [WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Credit covers every word from issue until pop, so it also bounds FIFO occupancy.
    assign issue      = (state == READ) && (rem != '0) && (credit < CREDIT_MAX);
    assign last_issue = issue && (rem == LEN_ONE);
    assign push       = pipe_en[L-1];
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? fifo_mem[rd_ptr][WIDTH-1:0] : '0;
    assign out_last   = out_valid && fifo_mem[rd_ptr][WIDTH];
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    always_comb begin
        credit_next = credit;
        case ({issue, pop})
            2'b10:   credit_next = credit + 1'b1;
            2'b01:   credit_next = credit - 1'b1;
            default: credit_next = credit;
        endcase
    end

    // Leaving DRAIN on the final pop lets cmd_ready rise in the very next cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid && (cmd_len != '0)) state_next = READ;
            READ:    if (last_issue) state_next = DRAIN;
            DRAIN:   if (credit_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            rem      <= '0;
            credit   <= '0;
            mem_en   <= 1'b0;
            mem_last <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_next;
            credit   <= credit_next;
            mem_en   <= issue;
            mem_last <= last_issue;
            if ((state == IDLE) && cmd_valid) begin
                addr <= cmd_addr;
                rem  <= cmd_len;
            end else if (issue) begin
                mem_addr <= addr;
                addr     <= addr + 1'b1;
                rem      <= rem - 1'b1;
            end
        end
    end

    // The last stage lines up with the cycle in which mem_do carries the read word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_en   <= '0;
            pipe_last <= '0;
        end else begin
            pipe_en[0]   <= mem_en;
            pipe_last[0] <= mem_last;
            for (int i = 1; i < L; i++) begin
                pipe_en[i]   <= pipe_en[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pipe_last[L-1], mem_do};
    end
endmodule

// File: tb/tb_dpmem_rd_stream.sv
// Scoreboard bench: two engines (read latency 1 and 2) share one command stream,
// each with its own RAM model, address queue and data queue checked by a monitor.
module tb_dpmem_rd_stream;
    localparam int DEPTH = 10;
    localparam int WIDTH = 32;
    localparam int TO    = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic [DEPTH-1:0] cmd_addr = '0;
    logic [DEPTH:0] cmd_len = '0;
    logic out_ready = 1'b0;

    logic cmd_ready [2];
    logic mem_en [2];
    logic out_valid [2];
    logic out_last [2];
    logic busy [2];
    logic [DEPTH-1:0] mem_addr [2];
    logic [WIDTH-1:0] mem_do [2];
    logic [WIDTH-1:0] out_data [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dpmem_rd_stream #(.DEPTH(DEPTH), .WIDTH(WIDTH), .OUTREG(0), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_en(mem_en[0]), .mem_addr(mem_addr[0]),
        .mem_do(mem_do[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_last(out_last[0]), .busy(busy[0]));

    dpmem_rd_stream #(.DEPTH(DEPTH), .WIDTH(WIDTH), .OUTREG(1), .FIFO_DEPTH(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_en(mem_en[1]), .mem_addr(mem_addr[1]),
        .mem_do(mem_do[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_last(out_last[1]), .busy(busy[1]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // RAM model holds mem[k] = A5000000 + k; OUTREG adds a second output stage.
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int L  = 1 + g;
        localparam int FD = 4 + g;
        logic [WIDTH-1:0] r1, r2;
        logic [WIDTH:0] exp_q [$];
        logic [DEPTH-1:0] addr_q [$];
        int cmd_edge, first_valid, last_pop, first_en, last_en;
        int outstanding = 0;
        int max_out = 0;
        bit want_en = 0, want_valid = 0, stalled = 0, ready_chk = 0;
        logic [WIDTH:0] held, exp;

        always @(posedge clk) begin
            if (mem_en[g]) r1 <= 32'hA500_0000 + 32'(mem_addr[g]);
            r2 <= r1;
        end
        assign mem_do[g] = (L == 1) ? r1 : r2;

        always @(negedge clk) begin
            if (!rst_n) begin
                outstanding = 0;
                stalled = 0;
                ready_chk = 0;
            end else begin
                if (ready_chk) begin
                    check($sformatf("dut%0d ready/busy after last pop", g), {cmd_ready[g], busy[g]}, 2'b10);
                    ready_chk = 0;
                end
                if (mem_en[g]) begin
                    if (want_en) begin
                        check($sformatf("dut%0d first mem_en cycle", g), cyc - cmd_edge, 1);
                        want_en = 0;
                        first_en = cyc;
                    end
                    last_en = cyc;
                    outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                    check($sformatf("dut%0d credit bound", g), outstanding <= FD, 1);
                    if (addr_q.size() == 0) fail($sformatf("dut%0d unexpected read at %0h", g, mem_addr[g]));
                    else check($sformatf("dut%0d mem_addr", g), mem_addr[g], addr_q.pop_front());
                end
                if (out_valid[g]) begin
                    if (want_valid) begin
                        check($sformatf("dut%0d first out_valid cycle", g), cyc - cmd_edge, 2 + L);
                        want_valid = 0;
                        first_valid = cyc;
                    end
                    if (stalled) check($sformatf("dut%0d stable while stalled", g), {out_last[g], out_data[g]}, held);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            fail($sformatf("dut%0d unexpected word %0h", g, out_data[g]));
                        end else begin
                            exp = exp_q.pop_front();
                            check($sformatf("dut%0d word {last,data}", g), {out_last[g], out_data[g]}, exp);
                            if (exp[WIDTH]) ready_chk = 1;
                        end
                        last_pop = cyc;
                        outstanding--;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        held = {out_last[g], out_data[g]};
                    end
                end else if (stalled) begin
                    fail($sformatf("dut%0d out_valid dropped while stalled", g));
                    stalled = 0;
                end
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while ((mon[0].exp_q.size() != 0 || mon[1].exp_q.size() != 0 ||
                !cmd_ready[0] || !cmd_ready[1]) && n < TO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TO) fail("timeout waiting for engines to finish");
    endtask

    task automatic apply_cmd(input int addr, input int len);
        int a;
        wait_done();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = DEPTH'(addr);
        cmd_len   = (DEPTH+1)'(len);
        for (int k = 0; k < len; k++) begin
            a = (addr + k) % (1 << DEPTH);
            mon[0].addr_q.push_back(DEPTH'(a));
            mon[1].addr_q.push_back(DEPTH'(a));
            mon[0].exp_q.push_back({k == len - 1, 32'hA500_0000 + 32'(a)});
            mon[1].exp_q.push_back({k == len - 1, 32'hA500_0000 + 32'(a)});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        mon[0].cmd_edge = cyc;
        mon[1].cmd_edge = cyc;
        if (len != 0) begin
            mon[0].want_en = 1; mon[0].want_valid = 1;
            mon[1].want_en = 1; mon[1].want_valid = 1;
        end
    endtask

    task automatic check_full_rate(input int len);
        check("dut0 output span", mon[0].last_pop - mon[0].first_valid, len - 1);
        check("dut1 output span", mon[1].last_pop - mon[1].first_valid, len - 1);
        check("dut0 mem_en span", mon[0].last_en - mon[0].first_en, len - 1);
        check("dut1 mem_en span", mon[1].last_en - mon[1].first_en, len - 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < 2; g++)
            check($sformatf("dut%0d %s outputs", g, tag),
                  {cmd_ready[g], mem_en[g], mem_addr[g], out_valid[g], out_data[g], out_last[g], busy[g]},
                  {1'b1, 1'b0, 10'd0, 1'b0, 32'd0, 1'b0, 1'b0});
    endtask

    initial begin
        bit act0, act1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;

        $display("[TB] basic burst addr=2 len=4");
        apply_cmd(2, 4);
        wait_done();
        check_full_rate(4);

        $display("[TB] burst addr=0 len=8");
        apply_cmd(0, 8);
        wait_done();
        check_full_rate(8);

        $display("[TB] wrap addr=1022 len=4");
        apply_cmd(1022, 4);
        wait_done();
        check_full_rate(4);

        $display("[TB] backpressure len=6");
        mon[0].max_out = 0;
        mon[1].max_out = 0;
        apply_cmd(40, 6);
        for (int i = 0; i < 300 && (mon[0].exp_q.size() != 0 || mon[1].exp_q.size() != 0); i++) begin
            @(posedge clk); #1;
            out_ready = (i % 5 == 0);
        end
        out_ready = 1'b1;
        wait_done();
        check("dut0 credit reached FIFO depth", mon[0].max_out, 4);
        check("dut1 credit reached FIFO depth", mon[1].max_out, 5);

        $display("[TB] zero-length command");
        apply_cmd(5, 0);
        act0 = 0;
        act1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_en[0] || out_valid[0] || !cmd_ready[0]) act0 = 1;
            if (mem_en[1] || out_valid[1] || !cmd_ready[1]) act1 = 1;
        end
        check("dut0 len0 no activity", act0, 0);
        check("dut1 len0 no activity", act1, 0);
        apply_cmd(7, 1);
        wait_done();

        $display("[TB] reset mid-burst");
        out_ready = 1'b0;
        apply_cmd(20, 8);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("mid-burst reset");
        for (int g = 0; g < 2; g++) begin
            if (g == 0) begin
                mon[0].exp_q.delete(); mon[0].addr_q.delete();
                mon[0].want_en = 0; mon[0].want_valid = 0;
            end else begin
                mon[1].exp_q.delete(); mon[1].addr_q.delete();
                mon[1].want_en = 0; mon[1].want_valid = 0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        apply_cmd(3, 2);
        wait_done();

        repeat (6) @(negedge clk);
        check("dut0 reads all consumed", mon[0].addr_q.size(), 0);
        check("dut1 reads all consumed", mon[1].addr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
